// File: rtl/lutram_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
// Default register-file geometry and write-request bundle.
package lutram_write_arbiter_pkg;

   localparam int RF_WIDTH  = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_ADDR_W = $clog2(RF_DEPTH);

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_WIDTH-1:0]  data;
   } wr_req_t;

   function automatic int unsigned rr_next(
      input int unsigned k,
      input int unsigned n
   );
      return (k + 1 >= n) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/lutram_write_arbiter_if.sv
// Writeback-source and LUTRAM-side bundle of the write arbiter.
// master: sources, readers and LUTRAM; slave: the arbiter.
interface lutram_write_arbiter_if
   import lutram_write_arbiter_pkg::*;
#(
   parameter int WIDTH           = RF_WIDTH,
   parameter int DEPTH           = RF_DEPTH,
   parameter int NUM_WRITE_PORTS = 3,
   parameter int NUM_READ_PORTS  = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_WRITE_PORTS-1:0]                wr_valid;
   logic [NUM_WRITE_PORTS-1:0]                wr_ready;
   logic [NUM_WRITE_PORTS-1:0][AW-1:0]        wr_addr;
   logic [NUM_WRITE_PORTS-1:0][WIDTH-1:0]     wr_data;
   logic                                      ram_write;
   logic [AW-1:0]                             waddr;
   logic [WIDTH-1:0]                          new_ram_data;
   logic [NUM_READ_PORTS-1:0][AW-1:0]         raddr;
   logic [NUM_READ_PORTS-1:0][WIDTH-1:0]      ram_data_out;
   logic [NUM_READ_PORTS-1:0][WIDTH-1:0]      rd_data;
   logic                                      pending;

   modport master (
      output wr_valid, wr_addr, wr_data,
      output raddr, ram_data_out,
      input  wr_ready, ram_write, waddr,
      input  new_ram_data, rd_data, pending
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      input  raddr, ram_data_out,
      output wr_ready, ram_write, waddr,
      output new_ram_data, rd_data, pending
   );

endinterface

// File: rtl/lutram_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: N requests to one-hot grant.
// Pointer moves past the winner whenever anything is granted.
module lutram_write_arbiter_rr_arbiter
   import lutram_write_arbiter_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] rr;
   int unsigned   k;

   // Scan from the farthest offset so the one nearest rr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      k     = 0;
      any   = |req;
      for (int o = N - 1; o >= 0; o--) begin
         k = (32'(rr) + 32'(o)) % N;
         if (req[IW'(k)]) idx = IW'(k);
      end
      grant[idx] = any;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= '0;
      end else if (any) begin
         rr <= IW'(rr_next(32'(idx), N));
      end
   end

endmodule

// File: rtl/lutram_write_arbiter.sv
// Merges writeback sources onto the single LUTRAM write port.
// Define LUTRAM_WB_FORWARD_EN to bypass the in-flight write to readers.
module lutram_write_arbiter
   import lutram_write_arbiter_pkg::*;
#(
   parameter int WIDTH           = RF_WIDTH,
   parameter int DEPTH           = RF_DEPTH,
   parameter int NUM_WRITE_PORTS = 3,
   parameter int NUM_READ_PORTS  = 2
) (
   input logic                   clk,
   input logic                   rst,
   lutram_write_arbiter_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = NUM_WRITE_PORTS;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } req_t;

   req_t [NW-1:0]  hreg;
   logic [NW-1:0]  held;
   logic [NW-1:0]  grant;
   logic [NW-1:0]  xfer;
   logic [IW-1:0]  gidx;
   logic           any_grant;

   lutram_write_arbiter_rr_arbiter #(
      .N  (NW),
      .IW (IW)
   ) arb (
      .clk   (clk),
      .rst   (rst),
      .req   (held),
      .grant (grant),
      .idx   (gidx),
      .any   (any_grant)
   );

   // A granted slot can be refilled at the same edge it drains.
   assign bus.wr_ready = ~held | grant;
   assign xfer         = bus.wr_valid & bus.wr_ready;
   assign bus.pending  = (|held) | bus.ram_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         held             <= '0;
         bus.ram_write    <= 1'b0;
         bus.waddr        <= '0;
         bus.new_ram_data <= '0;
      end else begin
         bus.ram_write <= any_grant;
         if (any_grant) begin
            bus.waddr        <= hreg[gidx].addr;
            bus.new_ram_data <= hreg[gidx].data;
         end
         for (int i = 0; i < NW; i++) begin
            if (xfer[i]) begin
               held[i] <= 1'b1;
               hreg[i] <= '{addr: bus.wr_addr[i],
                            data: bus.wr_data[i]};
            end else if (grant[i]) begin
               held[i] <= 1'b0;
            end
         end
      end
   end

`ifdef LUTRAM_WB_FORWARD_EN
   for (genvar j = 0; j < NUM_READ_PORTS; j++) begin : g_fwd
      assign bus.rd_data[j] =
         (bus.ram_write && bus.waddr == bus.raddr[j])
            ? bus.new_ram_data : bus.ram_data_out[j];
   end
`else
   assign bus.rd_data = bus.ram_data_out;
`endif

endmodule

// File: tb/tb_lutram_write_arbiter.sv
// Bench for lutram_write_arbiter: directed scenarios plus
// randomized traffic against a cycle model and a bench LUTRAM.
module tb_lutram_write_arbiter;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int N  = 3;
   localparam int R  = 2;
   localparam int AW = $clog2(D);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lutram_write_arbiter_if #(
      .WIDTH(W), .DEPTH(D),
      .NUM_WRITE_PORTS(N), .NUM_READ_PORTS(R)
   ) bus ();

   lutram_write_arbiter #(
      .WIDTH(W), .DEPTH(D),
      .NUM_WRITE_PORTS(N), .NUM_READ_PORTS(R)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0] lut [D];
   logic         init_lut = 1'b1;

   always @(posedge clk) begin
      if (init_lut) begin
         for (int i = 0; i < D; i++) lut[i] <= '0;
      end else if (bus.ram_write) begin
         lut[bus.waddr] <= bus.new_ram_data;
      end
   end

   for (genvar j = 0; j < R; j++) begin : g_lut
      assign bus.ram_data_out[j] = lut[bus.raddr[j]];
   end

   int total = 0;
   int bad   = 0;

   bit           m_held [N];
   logic [AW-1:0] m_ha   [N];
   logic [W-1:0]  m_hd   [N];
   int            m_rr;
   bit            m_wen;
   logic [AW-1:0] m_wa;
   logic [W-1:0]  m_wd;
   logic [W-1:0]  m_mem  [D];

   function automatic int m_pick();
      int k;
      for (int o = 0; o < N; o++) begin
         k = (m_rr + o) % N;
         if (m_held[k]) return k;
      end
      return -1;
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic compare();
      int g;
      bit any;
      logic [W-1:0] e;
      g = m_pick();
      any = m_wen;
      for (int i = 0; i < N; i++) begin
         chk("wr_ready", 64'(bus.wr_ready[i]),
             64'(!m_held[i] || g == i));
         any = any | m_held[i];
      end
      chk("ram_write", 64'(bus.ram_write), 64'(m_wen));
      if (m_wen) begin
         chk("waddr", 64'(bus.waddr), 64'(m_wa));
         chk("new_ram_data", 64'(bus.new_ram_data), 64'(m_wd));
      end
      chk("pending", 64'(bus.pending), 64'(any));
      for (int j = 0; j < R; j++) begin
         e = m_mem[bus.raddr[j]];
`ifdef LUTRAM_WB_FORWARD_EN
         if (m_wen && m_wa == bus.raddr[j]) e = m_wd;
`endif
         chk("rd_data", 64'(bus.rd_data[j]), 64'(e));
      end
   endtask

   task automatic model_update();
      int g;
      bit rdy [N];
      if (m_wen) m_mem[m_wa] = m_wd;
      if (rst) begin
         for (int i = 0; i < N; i++) m_held[i] = 1'b0;
         m_rr  = 0;
         m_wen = 1'b0;
      end else begin
         g = m_pick();
         for (int i = 0; i < N; i++) rdy[i] = !m_held[i] || g == i;
         if (g >= 0) begin
            m_wen = 1'b1;
            m_wa  = m_ha[g];
            m_wd  = m_hd[g];
            m_rr  = (g + 1) % N;
         end else begin
            m_wen = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (bus.wr_valid[i] && rdy[i]) begin
               m_held[i] = 1'b1;
               m_ha[i]   = bus.wr_addr[i];
               m_hd[i]   = bus.wr_data[i];
            end else if (g == i) begin
               m_held[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      #1 compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic put(input int i, input int a, input logic [W-1:0] d);
      bus.wr_addr[i] = AW'(a);
      bus.wr_data[i] = d;
   endtask

   task automatic do_reset();
      bus.wr_valid = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      for (int i = 0; i < N; i++) m_held[i] = 1'b0;
      m_rr  = 0;
      m_wen = 1'b0;
      m_wa  = '0;
      m_wd  = '0;
      bus.wr_valid = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.raddr    = '0;
      @(posedge clk);
      model_update();
      @(negedge clk);
      init_lut = 1'b0;

      do_reset();
      #1;
      chk("rst_ram_write", 64'(bus.ram_write), 64'd0);
      chk("rst_pending", 64'(bus.pending), 64'd0);
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'b111);
      chk("rst_waddr", 64'(bus.waddr), 64'd0);
      chk("rst_data", 64'(bus.new_ram_data), 64'd0);

      // single write
      bus.wr_valid = 3'b001;
      put(0, 5, 32'hDEADBEEF);
      tick();
      bus.wr_valid = '0;
      tick();
      #1;
      chk("single_wen", 64'(bus.ram_write), 64'd1);
      chk("single_waddr", 64'(bus.waddr), 64'd5);
      chk("single_data", 64'(bus.new_ram_data), 64'hDEADBEEF);
      bus.raddr[0] = AW'(5);
      tick();
      #1;
      chk("single_read", 64'(bus.rd_data[0]), 64'hDEADBEEF);

      // three sources at once
      do_reset();
      bus.wr_valid = 3'b111;
      put(0, 1, 32'hA1);
      put(1, 2, 32'hA2);
      put(2, 3, 32'hA3);
      tick();
      bus.wr_valid = '0;
      tick();
      #1;
      chk("rr3_wen0", 64'(bus.ram_write), 64'd1);
      chk("rr3_addr0", 64'(bus.waddr), 64'd1);
      chk("rr3_rdy0", 64'(bus.wr_ready), 64'b011);
      tick();
      #1;
      chk("rr3_addr1", 64'(bus.waddr), 64'd2);
      chk("rr3_rdy1", 64'(bus.wr_ready), 64'b111);
      tick();
      #1;
      chk("rr3_addr2", 64'(bus.waddr), 64'd3);
      tick();
      #1;
      chk("rr3_idle", 64'(bus.ram_write), 64'd0);
      bus.wr_valid = 3'b011;
      put(0, 10, 32'h10);
      put(1, 11, 32'h11);
      tick();
      bus.wr_valid = '0;
      tick();
      #1;
      chk("rr_wrap_first", 64'(bus.waddr), 64'd10);
      tick();
      #1;
      chk("rr_wrap_second", 64'(bus.waddr), 64'd11);
      tick();

      // back-to-back on source 1
      do_reset();
      for (int c = 0; c < 6; c++) begin
         bus.wr_valid = 3'b010;
         put(1, c, 32'(100 + c));
         #1;
         chk("b2b_ready", 64'(bus.wr_ready[1]), 64'd1);
         if (c >= 2) begin
            chk("b2b_wen", 64'(bus.ram_write), 64'd1);
            chk("b2b_data", 64'(bus.new_ram_data), 64'(100 + c - 2));
         end
         tick();
      end
      bus.wr_valid = '0;
      tick();
      tick();

      // same address, rr=2
      do_reset();
      bus.wr_valid = 3'b010;
      put(1, 0, 32'h55);
      tick();
      bus.wr_valid = '0;
      tick();
      bus.wr_valid = 3'b101;
      put(0, 7, 32'h11);
      put(2, 7, 32'h22);
      tick();
      bus.wr_valid = '0;
      tick();
      #1;
      chk("same_first", 64'(bus.new_ram_data), 64'h22);
      tick();
      #1;
      chk("same_second", 64'(bus.new_ram_data), 64'h11);
      tick();
      bus.raddr[0] = AW'(7);
      #1;
      chk("same_final", 64'(bus.rd_data[0]), 64'h11);

      // forwarding window
      do_reset();
      bus.wr_valid = 3'b001;
      put(0, 9, 32'hAB);
      tick();
      bus.wr_valid = '0;
      tick();
      bus.raddr[0] = AW'(9);
      #1;
`ifdef LUTRAM_WB_FORWARD_EN
      chk("fwd_read", 64'(bus.rd_data[0]), 64'hAB);
`else
      chk("fwd_read", 64'(bus.rd_data[0]), 64'h0);
`endif
      tick();
      #1;
      chk("fwd_commit", 64'(bus.rd_data[0]), 64'hAB);

      // reset with three entries held
      do_reset();
      bus.wr_valid = 3'b111;
      put(0, 20, 32'h1);
      put(1, 21, 32'h2);
      put(2, 22, 32'h3);
      tick();
      bus.wr_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_wen", 64'(bus.ram_write), 64'd0);
      chk("mid_rst_pending", 64'(bus.pending), 64'd0);
      chk("mid_rst_ready", 64'(bus.wr_ready), 64'b111);
      bus.raddr[0] = AW'(20);
      bus.raddr[1] = AW'(22);
      tick();
      tick();
      #1;
      chk("mid_rst_mem0", 64'(bus.rd_data[0]), 64'd0);
      chk("mid_rst_mem1", 64'(bus.rd_data[1]), 64'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 249) == 0);
         bus.wr_valid = N'($urandom);
         for (int i = 0; i < N; i++)
            put(i, $urandom_range(0, 7), $urandom);
         for (int j = 0; j < R; j++)
            bus.raddr[j] = AW'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b0;
      bus.wr_valid = '0;
      for (int c = 0; c < 6; c++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lutram_write_arbiter.md
# lutram_write_arbiter

Merges several writeback sources onto the single write port of the register-file LUTRAM (1 write, multi-read). Each source gets a one-entry holding register with a valid/ready handshake. A round-robin arbiter selects one held entry per cycle into a registered write port. Optional read-side forwarding returns the in-flight write to readers before the LUTRAM commits it.

## Interface
Parameters:
- WIDTH, 32, data width
- DEPTH, 32, LUTRAM entries; address width is $clog2(DEPTH)
- NUM_WRITE_PORTS, 3, writeback sources (≥1)
- NUM_READ_PORTS, 2, read ports passed through / forwarded

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  [NUM_WRITE_PORTS]  source i has a write
- wr_ready  out  [NUM_WRITE_PORTS]  source i write accepted this edge
- wr_addr  in  [NUM_WRITE_PORTS][$clog2(DEPTH)]  write address per source
- wr_data  in  [NUM_WRITE_PORTS][WIDTH]  write data per source
- ram_write  out  1  registered write enable to LUTRAM
- waddr  out  $clog2(DEPTH)  registered write address
- new_ram_data  out  WIDTH  registered write data
- raddr  in  [NUM_READ_PORTS][$clog2(DEPTH)]  read addresses (same as driven to LUTRAM)
- ram_data_out  in  [NUM_READ_PORTS][WIDTH]  LUTRAM asynchronous read data
- rd_data  out  [NUM_READ_PORTS][WIDTH]  read data to consumers
- pending  out  1  any holding register or output register valid

## Operation
- Holding register per source: held[i], haddr[i], hdata[i].
- wr_ready[i] = ~held[i] | grant[i]. A transfer occurs when wr_valid[i] & wr_ready[i].
- Arbitration is combinational over held[]. It is round-robin from pointer rr: the first held index at or after rr (mod N) gets grant.
- On grant k at an edge:
  - output register loads {1, haddr[k], hdata[k]}.
  - held[k] clears unless a new transfer lands on k at the same edge; in that case it refills.
  - rr ← (k+1) mod N.
- No grant: ram_write ← 0, and rr is unchanged.
- Same address held by two sources: the LUTRAM is written in grant order, so the last granted value wins. There is no coalescing.
- NUM_WRITE_PORTS=1: rr stays 0 and the block acts as a 2-stage pipeline that accepts every cycle.
- Reset: held[]=0, rr=0, ram_write=0, waddr=0, new_ram_data=0, pending=0. wr_ready resets to all 1s. Any in-flight data is discarded, including a reset that arrives mid-operation.

## Timing
- A transfer at edge E0 fills the holding register.
- Earliest grant is in the cycle after E0, with the output register loaded at E1.
- ram_write=1 during E1→E2, and the LUTRAM commits at E2.
- Minimum latency from accept to committed write is 2 edges. Sustained throughput is 1 write/cycle aggregate.
- Worst-case wait for a held entry is NUM_WRITE_PORTS−1 cycles, so there is no starvation.
- wr_ready has a combinational path from held/grant only, never from wr_valid.

## Configuration
- LUTRAM_WB_FORWARD_EN defined: rd_data[j] = new_ram_data when ram_write & (waddr == raddr[j]); otherwise rd_data[j] = ram_data_out[j].
- Undefined: rd_data[j] = ram_data_out[j]. The new value is visible only after the commit edge.
- Holding-register contents are never forwarded in either configuration.

## Structure
- In cva5_types: a write-request struct {addr, data} parameterised through localparams derived from the register-file depth/width.
- One sub-module is natural: rr_arbiter (NUM_WRITE_PORTS requests → one-hot grant, pointer update on advance). It is reusable elsewhere in the core.
- The LUTRAM itself is instantiated by the parent, not inside this block.

## Test plan
- Single write: source 0 writes addr 5, data 0xDEADBEEF at E0 → ram_write=1, waddr=5 during E1→E2, and read of addr 5 returns 0xDEADBEEF from E2.
- Three sources valid at the same edge with addrs 1/2/3, rr=0 → ram_write on three consecutive cycles in order 1,2,3, and rr ends at 0. Each wr_ready re-asserts the cycle its entry is granted.
- Back-to-back on source 1 with other sources idle → 1 write/cycle sustained, wr_ready[1] held at 1.
- Sources 0 and 2 both write addr 7 (0x11, 0x22) with rr=2 → final LUTRAM value 0x11.
- With forwarding: raddr[0]=9 while ram_write=1, waddr=9, new_ram_data=0xAB → rd_data[0]=0xAB in that same cycle. Without forwarding, rd_data[0] shows the old value.
- rst asserted while 3 entries are held → next cycle ram_write=0, pending=0, wr_ready=all 1s, and no LUTRAM write occurs.
